// File: rtl/morse_digit_transmitter.sv
// Plays a 4-bit hex digit out as timed Morse code on a single on/off line.
// A start strobe latches the digit's pattern; the FSM then walks the symbols
// (mark, inter-symbol gap, ..., trailing letter space) and pulses done.
// All outputs come straight from flops, so morse_out never glitches.
module morse_digit_transmitter #(
  parameter int UNIT_CYCLES = 12500000,
  parameter int CNT_W       = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] digit,
  output logic       morse_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARK,
    S_GAP,
    S_TAIL,
    S_DONE
  } state_e;

  // pat bit 0 is the first symbol sent; a 1 bit is a dash.
  typedef struct packed {
    logic [4:0] pat;
    logic [2:0] len;
  } code_t;

  // Counter reload values: the counter runs from the load value down to zero,
  // so a load of N-1 spans exactly N cycles.
  localparam logic [CNT_W-1:0] UNIT_LOAD   = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TRIPLE_LOAD = CNT_W'(3 * UNIT_CYCLES - 1);

  function automatic code_t encode(input logic [3:0] d);
    code_t c;
    c = '0;
    case (d)
      4'h0: c = '{pat: 5'b11111, len: 3'd5};
      4'h1: c = '{pat: 5'b11110, len: 3'd5};
      4'h2: c = '{pat: 5'b11100, len: 3'd5};
      4'h3: c = '{pat: 5'b11000, len: 3'd5};
      4'h4: c = '{pat: 5'b10000, len: 3'd5};
      4'h5: c = '{pat: 5'b00000, len: 3'd5};
      4'h6: c = '{pat: 5'b00001, len: 3'd5};
      4'h7: c = '{pat: 5'b00011, len: 3'd5};
      4'h8: c = '{pat: 5'b00111, len: 3'd5};
      4'h9: c = '{pat: 5'b01111, len: 3'd5};
      4'hA: c = '{pat: 5'b00010, len: 3'd2};
      4'hB: c = '{pat: 5'b00001, len: 3'd4};
      4'hC: c = '{pat: 5'b00101, len: 3'd4};
      4'hD: c = '{pat: 5'b00001, len: 3'd3};
      4'hE: c = '{pat: 5'b00000, len: 3'd1};
      4'hF: c = '{pat: 5'b00100, len: 3'd4};
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       pat_q, pat_d;
  logic [2:0]       len_q, len_d;
  logic [2:0]       idx_q, idx_d;
  logic             morse_q, morse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  code_t            code;
  logic [2:0]       idx_next;
  logic [7:0]       pat_ext;
  logic             cnt_zero;

  assign code     = encode(digit);
  assign idx_next = idx_q + 3'd1;
  assign pat_ext  = {3'b000, pat_q};
  assign cnt_zero = (cnt_q == '0);

  // Next-state, counter reloads and registered-output precompute.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_MARK;
          pat_d   = code.pat;
          len_d   = code.len;
          idx_d   = '0;
          cnt_d   = code.pat[0] ? TRIPLE_LOAD : UNIT_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MARK: begin
        if (cnt_zero) begin
          if (idx_next < len_q) begin
            state_d = S_GAP;
            cnt_d   = UNIT_LOAD;
          end else begin
            state_d = S_TAIL;
            cnt_d   = TRIPLE_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_zero) begin
          state_d = S_MARK;
          idx_d   = idx_next;
          cnt_d   = pat_ext[idx_next] ? TRIPLE_LOAD : UNIT_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_TAIL: begin
        if (cnt_zero) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    morse_d = (state_d == S_MARK);
    busy_d  = (state_d == S_MARK) || (state_d == S_GAP) || (state_d == S_TAIL);
    done_d  = (state_d == S_DONE);
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      morse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      morse_q <= morse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign morse_out = morse_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_morse_digit_transmitter.sv
// Directed bench for morse_digit_transmitter with UNIT_CYCLES=2.
// Waveforms are recorded cycle by cycle after the start strobe and compared
// against hand-built expected bit patterns (bit i = cycle i+1).
module tb_morse_digit_transmitter;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] digit;
  logic       morse_out;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  logic [63:0] mv, bv, dv;

  morse_digit_transmitter #(
    .UNIT_CYCLES(2),
    .CNT_W      (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .digit    (digit),
    .morse_out(morse_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string seg(input int n, input string c);
    string r;
    r = "";
    for (int i = 0; i < n; i++) r = {r, c};
    return r;
  endfunction

  function automatic logic [63:0] wave(input string s);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < s.len() && i < 64; i++) w[i] = (s.getc(i) == 8'h31);
    return w;
  endfunction

  // Pulse start for one cycle; returns at the sample point of cycle 1.
  task automatic send(input logic [3:0] d);
    @(negedge clk);
    start = 1'b1;
    digit = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Record n cycles of outputs. After sampling index poke_at, start is raised
  // with poke_digit for one cycle; after sampling index rst_at, rst is pulled
  // low for one cycle. Use -1 to disable either.
  task automatic capture(input int n, input int poke_at, input logic [3:0] poke_digit,
                         input int rst_at);
    mv = '0;
    bv = '0;
    dv = '0;
    for (int i = 0; i < n; i++) begin
      mv[i] = morse_out;
      bv[i] = busy;
      dv[i] = done;
      if (i == poke_at) begin
        start = 1'b1;
        digit = poke_digit;
      end else begin
        start = 1'b0;
      end
      rst = (i == rst_at) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    rst   = 1'b1;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    start = 1'b0;
    digit = 4'hE;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({morse_out, busy, done} !== 3'b000) begin
        bad++;
        $display("FAIL reset_hold[%0d] got=%b want=000", k, {morse_out, busy, done});
      end
      start = (k == 1);
    end
    start = 1'b0;
    rst   = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if ({morse_out, busy, done} !== 3'b000) begin
        bad++;
        $display("FAIL reset_release[%0d] got=%b want=000", k, {morse_out, busy, done});
      end
    end
  endtask

  task automatic test_digit_e();
    logic [63:0] em, eb, ed;
    em = wave({seg(2, "1"), seg(8, "0")});
    eb = wave({seg(8, "1"), seg(2, "0")});
    ed = wave({seg(8, "0"), "1", "0"});
    send(4'hE);
    capture(10, -1, 4'h0, -1);
    total++;
    if (mv !== em) begin bad++; $display("FAIL e_morse got=%h want=%h", mv, em); end
    total++;
    if (bv !== eb) begin bad++; $display("FAIL e_busy got=%h want=%h", bv, eb); end
    total++;
    if (dv !== ed) begin bad++; $display("FAIL e_done got=%h want=%h", dv, ed); end
  endtask

  task automatic test_digit_a();
    logic [63:0] em, eb, ed;
    em = wave({seg(2, "1"), seg(2, "0"), seg(6, "1"), seg(8, "0")});
    eb = wave({seg(16, "1"), seg(2, "0")});
    ed = wave({seg(16, "0"), "1", "0"});
    send(4'hA);
    capture(18, -1, 4'h0, -1);
    total++;
    if (mv !== em) begin bad++; $display("FAIL a_morse got=%h want=%h", mv, em); end
    total++;
    if (bv !== eb) begin bad++; $display("FAIL a_busy got=%h want=%h", bv, eb); end
    total++;
    if (dv !== ed) begin bad++; $display("FAIL a_done got=%h want=%h", dv, ed); end
  endtask

  task automatic test_long_digits();
    logic [63:0] em, eb, ed;
    // 0: five dashes, busy (15+4+3)*2 = 44 cycles.
    em = wave({seg(6, "1"), seg(2, "0"), seg(6, "1"), seg(2, "0"), seg(6, "1"), seg(2, "0"),
               seg(6, "1"), seg(2, "0"), seg(6, "1"), seg(8, "0")});
    eb = wave({seg(44, "1"), seg(2, "0")});
    ed = wave({seg(44, "0"), "1", "0"});
    send(4'h0);
    capture(46, -1, 4'h0, -1);
    total++;
    if (mv !== em) begin bad++; $display("FAIL zero_morse got=%h want=%h", mv, em); end
    total++;
    if (bv !== eb) begin bad++; $display("FAIL zero_busy got=%h want=%h", bv, eb); end
    total++;
    if (dv !== ed) begin bad++; $display("FAIL zero_done got=%h want=%h", dv, ed); end
    // 5: five dots, busy (5+4+3)*2 = 24 cycles.
    em = wave({seg(2, "1"), seg(2, "0"), seg(2, "1"), seg(2, "0"), seg(2, "1"), seg(2, "0"),
               seg(2, "1"), seg(2, "0"), seg(2, "1"), seg(8, "0")});
    eb = wave({seg(24, "1"), seg(2, "0")});
    ed = wave({seg(24, "0"), "1", "0"});
    send(4'h5);
    capture(26, -1, 4'h0, -1);
    total++;
    if (mv !== em) begin bad++; $display("FAIL five_morse got=%h want=%h", mv, em); end
    total++;
    if (bv !== eb) begin bad++; $display("FAIL five_busy got=%h want=%h", bv, eb); end
    total++;
    if (dv !== ed) begin bad++; $display("FAIL five_done got=%h want=%h", dv, ed); end
  endtask

  task automatic test_ignore_start();
    logic [63:0] em, eb, ed;
    // 7 = --... : busy (6+6+2+2+2 + 4*2 + 6) = 32 cycles; digit stays 3 afterwards.
    em = wave({seg(6, "1"), seg(2, "0"), seg(6, "1"), seg(2, "0"), seg(2, "1"), seg(2, "0"),
               seg(2, "1"), seg(2, "0"), seg(2, "1"), seg(14, "0")});
    eb = wave({seg(32, "1"), seg(8, "0")});
    ed = wave({seg(32, "0"), "1", seg(7, "0")});
    send(4'h7);
    capture(40, 3, 4'h3, -1);
    total++;
    if (mv !== em) begin bad++; $display("FAIL busy_start_morse got=%h want=%h", mv, em); end
    total++;
    if (bv !== eb) begin bad++; $display("FAIL busy_start_busy got=%h want=%h", bv, eb); end
    total++;
    if (dv !== ed) begin bad++; $display("FAIL busy_start_done got=%h want=%h", dv, ed); end
  endtask

  task automatic test_reset_abort();
    logic [63:0] em, eb, ed;
    // B = -... ; second mark starts in cycle 9, reset sampled at end of cycle 9.
    em = wave({seg(6, "1"), seg(2, "0"), "1", seg(7, "0")});
    eb = wave({seg(9, "1"), seg(7, "0")});
    ed = '0;
    send(4'hB);
    capture(16, -1, 4'h0, 8);
    total++;
    if (mv !== em) begin bad++; $display("FAIL abort_morse got=%h want=%h", mv, em); end
    total++;
    if (bv !== eb) begin bad++; $display("FAIL abort_busy got=%h want=%h", bv, eb); end
    total++;
    if (dv !== ed) begin bad++; $display("FAIL abort_done got=%h want=%h", dv, ed); end
    em = wave({seg(2, "1"), seg(8, "0")});
    eb = wave({seg(8, "1"), seg(2, "0")});
    ed = wave({seg(8, "0"), "1", "0"});
    send(4'hE);
    capture(10, -1, 4'h0, -1);
    total++;
    if ({mv, bv, dv} !== {em, eb, ed}) begin
      bad++;
      $display("FAIL abort_then_e got=%h/%h/%h want=%h/%h/%h", mv, bv, dv, em, eb, ed);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] em, eb, ed;
    // Second E accepted in the done cycle (cycle 9); its mark starts in cycle 10.
    em = wave({seg(2, "1"), seg(7, "0"), seg(2, "1"), seg(9, "0")});
    eb = wave({seg(8, "1"), "0", seg(8, "1"), seg(3, "0")});
    ed = wave({seg(8, "0"), "1", seg(8, "0"), "1", seg(2, "0")});
    send(4'hE);
    capture(20, 8, 4'hE, -1);
    total++;
    if (mv !== em) begin bad++; $display("FAIL b2b_morse got=%h want=%h", mv, em); end
    total++;
    if (bv !== eb) begin bad++; $display("FAIL b2b_busy got=%h want=%h", bv, eb); end
    total++;
    if (dv !== ed) begin bad++; $display("FAIL b2b_done got=%h want=%h", dv, ed); end
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    digit = 4'h0;
    test_reset();
    test_digit_e();
    test_digit_a();
    test_long_digits();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
